// File: rtl/jk_counter_ctrl_if.sv
// Handshake-free control/status bundle for jk_counter_ctrl.
// Master drives count/load controls; slave returns state and excitation.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UD;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             CO;
  logic             ERR;

  modport master (
    output EN, UD, LD, D,
    input  Q, J, K, CO, ERR
  );

  modport slave (
    input  EN, UD, LD, D,
    output Q, J, K, CO, ERR
  );
endinterface

// File: rtl/jk_counter_ctrl.sv
// Modulo-N up/down counter with parallel load that also exports
// JK excitation for a mirror bank of JK flip-flops on the same clock.
module jk_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               CK,
  input  logic               RB,
  jk_counter_ctrl_if.slave   bus
);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic             r_err;

  logic [WIDTH-1:0] w_qnext;
  logic             w_wrap;
  logic             w_err;

  // Compare against the bound before stepping so nothing overflows WIDTH.
  always_comb begin
    w_qnext = r_q;
    w_wrap  = 1'b0;
    w_err   = 1'b0;
    if (!RB) begin
      w_qnext = '0;
    end else if (bus.LD) begin
      if ({1'b0, bus.D} < LP_MOD) begin
        w_qnext = bus.D;
      end else begin
        w_qnext = '0;
        w_err   = 1'b1;
      end
    end else if (bus.EN) begin
      if (bus.UD) begin
        if (r_q == LP_MAX) begin
          w_qnext = '0;
          w_wrap  = 1'b1;
        end else begin
          w_qnext = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_qnext = LP_MAX;
          w_wrap  = 1'b1;
        end else begin
          w_qnext = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RB) begin
      r_q   <= '0;
      r_co  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_qnext;
      r_co  <= w_wrap;
      r_err <= w_err;
    end
  end

  // Set only rising bits, reset only falling bits; J&K is never both 1.
  assign bus.J   = ~r_q & w_qnext;
  assign bus.K   = r_q & ~w_qnext;
  assign bus.Q   = r_q;
  assign bus.CO  = r_co;
  assign bus.ERR = r_err;
endmodule
